// File: rtl/hdr_queue_if.sv
// Handshake bundle between the header queue, its producer and the processing stage.
// The master side pushes and pops; the slave side is the queue itself.
interface hdr_queue_if #(
    parameter int DEPTH       = 4,
    parameter int DROP_W      = 16,
    parameter int HDR_MAX_LEN = 4,
    parameter int NUM_PORTS   = 4
);
    logic                                wr_i;
    logic [HDR_MAX_LEN-1:0][7:0]         pkt_hdr_i;
    logic [NUM_PORTS-1:0]                out_port_i;
    logic                                full_o;
    logic                                rd_i;
    logic                                empty_o;
    logic [HDR_MAX_LEN-1:0][7:0]         pkt_hdr_o;
    logic [NUM_PORTS-1:0]                out_port_o;
    logic [$clog2(DEPTH):0]              level_o;
    logic [DROP_W-1:0]                   drop_cnt_o;

    modport master (
        output wr_i, pkt_hdr_i, out_port_i, rd_i,
        input  full_o, empty_o, pkt_hdr_o, out_port_o, level_o, drop_cnt_o
    );

    modport slave (
        input  wr_i, pkt_hdr_i, out_port_i, rd_i,
        output full_o, empty_o, pkt_hdr_o, out_port_o, level_o, drop_cnt_o
    );
endinterface

// File: rtl/hdr_queue.sv
// First-word-fall-through FIFO of packet headers and egress port masks.
// Writes arriving while full (without a same-cycle pop) are dropped and counted.
module hdr_queue #(
    parameter int DEPTH       = 4,
    parameter int DROP_W      = 16,
    parameter int HDR_MAX_LEN = 4,
    parameter int NUM_PORTS   = 4
) (
    input logic        clk,
    input logic        rst,
    hdr_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef logic [HDR_MAX_LEN-1:0][7:0] hdr_t;

    hdr_t                 hdr_mem  [DEPTH];
    logic [NUM_PORTS-1:0] port_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    logic [LVL_W-1:0]     level_nxt;
    logic                 full;
    logic                 empty;
    logic [DROP_W-1:0]    drop_cnt;
    logic                 push;
    logic                 pop;
    logic                 drop;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    // A pop in the same cycle frees the slot a push into a full queue needs.
    always_comb begin
        pop  = q.rd_i && !empty;
        push = q.wr_i && (!full || pop);
        drop = q.wr_i && full && !pop;
        unique case ({push, pop})
            2'b10:   level_nxt = level + LVL_W'(1);
            2'b01:   level_nxt = level - LVL_W'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                hdr_mem[i]  <= '0;
                port_mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                hdr_mem[wr_ptr]  <= q.pkt_hdr_i;
                port_mem[wr_ptr] <= q.out_port_i;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
            level <= level_nxt;
            full  <= (level_nxt == LVL_W'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

    assign q.pkt_hdr_o  = hdr_mem[rd_ptr];
    assign q.out_port_o = port_mem[rd_ptr];
    assign q.full_o     = full;
    assign q.empty_o    = empty;
    assign q.level_o    = level;
    assign q.drop_cnt_o = drop_cnt;
endmodule
